spi_txn_arbiter: RTL

Transaction-level arbiter and sequencer that lets two requesters share the single-byte `spi_master` engine in `fpga_spi_top`. Requester 0 is the UART bridge path and requester 1 is a local housekeeping/poll source. The block grants the engine round-robin, holds the grant for a multi-byte transaction, and issues one `start_tx` per byte. It returns each received byte to the owner and can abort a transaction whose engine never completes.

---
 rtl/spi_txn_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that sequences multi-byte transactions from two requesters onto one single-byte SPI engine; grant 1 cycle after request, one byte per start/done handshake.
// Optional watchdog abort of a stalled engine byte is built only when SPI_ARB_WDOG_EN is defined.
module spi_txn_arbiter #(
  parameter int WDOG_CYCLES = 4096,
  parameter int WDOG_W      = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] txd0,
  input  logic [7:0] txd1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       rx_valid0,
  output logic       rx_valid1,
  output logic [7:0] rxd,
  output logic       owner,
  output logic       busy,
  output logic       err,
  output logic [7:0] eng_tx_data,
  output logic       eng_start,
  input  logic [7:0] eng_rx_data,
  input  logic       eng_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RETURN} state_t;

  state_t     state_q;
  logic       owner_q;
  logic       prio_last_q;
  logic       last_q;
  logic       ack0_q, ack1_q;
  logic       rx_valid0_q, rx_valid1_q;
  logic [7:0] rxd_q;
  logic [7:0] eng_tx_data_q;
  logic       eng_start_q;

  logic       grant_d;
  logic       issue_own_d;
  logic       issue_d;
  logic       own_req;

  // A new byte is issued either on a fresh grant or when a locked burst continues.
  always_comb begin
    grant_d = owner_q;
    if (req0 && req1) grant_d = ~prio_last_q;
    else if (req1)    grant_d = 1'b1;
    else if (req0)    grant_d = 1'b0;
    own_req     = owner_q ? req1 : req0;
    issue_own_d = (state_q == ST_IDLE) ? grant_d : owner_q;
    issue_d     = ((state_q == ST_IDLE) && (req0 || req1)) ||
                  ((state_q == ST_RETURN) && !last_q && own_req);
  end

`ifdef SPI_ARB_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      prio_last_q   <= 1'b1;
      last_q        <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rx_valid0_q   <= 1'b0;
      rx_valid1_q   <= 1'b0;
      rxd_q         <= 8'h00;
      eng_tx_data_q <= 8'h00;
      eng_start_q   <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
      wdog_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rx_valid0_q <= 1'b0;
      rx_valid1_q <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
      err_q       <= 1'b0;
`endif
      if (issue_d) begin
        state_q       <= ST_ISSUE;
        owner_q       <= issue_own_d;
        eng_tx_data_q <= issue_own_d ? txd1 : txd0;
        last_q        <= issue_own_d ? last1 : last0;
        eng_start_q   <= 1'b1;
        ack0_q        <= ~issue_own_d;
        ack1_q        <= issue_own_d;
`ifdef SPI_ARB_WDOG_EN
        wdog_q        <= '0;
`endif
      end else begin
        case (state_q)
          ST_ISSUE: begin
            state_q <= ST_WAIT;
`ifdef SPI_ARB_WDOG_EN
            wdog_q  <= wdog_q + 1'b1;
`endif
          end
          ST_WAIT: begin
`ifdef SPI_ARB_WDOG_EN
            // Counter equals cycles elapsed since eng_start; abort beats a coincident done.
            wdog_q <= wdog_q + 1'b1;
            if (wdog_q == WDOG_W'(WDOG_CYCLES)) begin
              state_q     <= ST_IDLE;
              prio_last_q <= owner_q;
            end else if (eng_done) begin
              rxd_q       <= eng_rx_data;
              rx_valid0_q <= ~owner_q;
              rx_valid1_q <= owner_q;
              state_q     <= ST_RETURN;
            end
            if ((wdog_q == WDOG_W'(WDOG_CYCLES - 1)) && !eng_done) err_q <= 1'b1;
`else
            if (eng_done) begin
              rxd_q       <= eng_rx_data;
              rx_valid0_q <= ~owner_q;
              rx_valid1_q <= owner_q;
              state_q     <= ST_RETURN;
            end
`endif
          end
          ST_RETURN: begin
            state_q     <= ST_IDLE;
            prio_last_q <= owner_q;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rx_valid0   = rx_valid0_q;
  assign rx_valid1   = rx_valid1_q;
  assign rxd         = rxd_q;
  assign owner       = owner_q;
  assign busy        = (state_q != ST_IDLE);
  assign eng_tx_data = eng_tx_data_q;
  assign eng_start   = eng_start_q;
`ifdef SPI_ARB_WDOG_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule
